// File: rtl/multu_unit_pkg.sv
// Pipeline-wide ALU operation codes and the state encoding of the iterative multiplier.
package multu_unit_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_ADDU  = 4'b1001;
    localparam logic [3:0] ALU_SUBU  = 4'b1010;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } multu_state_e;

endpackage

// File: rtl/multu_datapath.sv
// Shift-add multiply datapath: multiplicand, accumulator/multiplier shift pair and step counter.
module multu_datapath #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               last,
    output logic [2*WIDTH-1:0] product_next
);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH:0]   sum;

    // The carry out of the add lands in acc's MSB after the right shift, so nothing is lost.
    always_comb begin
        sum          = {1'b0, acc_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
        product_next = {sum, mplier_reg[WIDTH-1:1]};
        last         = (count_reg == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (load) begin
            mcand_reg  <= mcand_in;
            acc_reg    <= '0;
            mplier_reg <= mplier_in;
            count_reg  <= '0;
        end else if (step) begin
            {acc_reg, mplier_reg} <= product_next;
            count_reg             <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/multu_unit.sv
// EX-stage MULTU sequencer: stalls the pipe for the iterative multiply and commits HI/LO.
module multu_unit
    import multu_unit_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MULTU_OP = ALU_MULTU
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    multu_state_e       state_reg;
    multu_state_e       state_next;
    logic               req;
    logic               load;
    logic               step;
    logic               commit;
    logic               last;
    logic [2*WIDTH-1:0] product_next;

    assign req = ex_valid & (alu_op == MULTU_OP) & ~flush;

    multu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .mcand_in     (rs_val),
        .mplier_in    (rt_val),
        .last         (last),
        .product_next (product_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    load       = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        commit     = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A req still present here is the same instruction; never restart on it.
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= product_next[2*WIDTH-1:WIDTH];
            lo <= product_next[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_multu_unit.sv
// Randomized bench for multu_unit against a plain-arithmetic HI/LO and stall-length model.
module tb_multu_unit;
    import multu_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  alu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    multu_unit dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .alu_op   (alu_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full MULTU: expects 33 stall cycles, then a done cycle carrying a*b in HI/LO.
    task automatic do_multu(input logic [31:0] a, input logic [31:0] b, input bit toggle);
        logic [63:0] p;
        int cyc;
        p = {32'd0, a} * {32'd0, b};
        @(negedge clk);
        ex_valid = 1'b1; alu_op = ALU_MULTU; rs_val = a; rt_val = b; flush = 1'b0;
        #1;
        check("hilo_held_at_start", {hi, lo}, {exp_hi, exp_lo});
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            if (toggle) begin
                rs_val = $urandom;
                rt_val = $urandom;
            end
            #1;
        end
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        check("stall_cycles", 64'(cyc), 64'd33);
        check("done_pulse", {63'd0, done}, 64'd1);
        check("product", {hi, lo}, p);
        $display("[TB] multu 0x%08h * 0x%08h -> hi=0x%08h lo=0x%08h stall=%0d", a, b, hi, lo, cyc);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ex_valid = 1'b0; alu_op = ALU_NOP; flush = 1'b0;
        #1;
        check("idle_done", {62'd0, stall, done}, 64'd0);
        check("idle_hilo", {hi, lo}, {exp_hi, exp_lo});
    endtask

    // Start a MULTU and squash it in busy cycle k: no commit, no done.
    task automatic do_flush(input logic [31:0] a, input logic [31:0] b, input int k);
        bit seen;
        @(negedge clk);
        ex_valid = 1'b1; alu_op = ALU_MULTU; rs_val = a; rt_val = b; flush = 1'b0;
        #1;
        check("flush_start_stall", {63'd0, stall}, 64'd1);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        check("flush_cycle_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        #1;
        check("flush_after", {62'd0, stall, done}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done || stall) seen = 1'b1;
        end
        check("flush_no_done", {63'd0, seen}, 64'd0);
        check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
        $display("[TB] flush at busy cycle %0d, hi=0x%08h lo=0x%08h", k, hi, lo);
    endtask

    // Non-starting request shapes: stall/done stay low and HI/LO do not move.
    task automatic no_start(input logic v, input logic [3:0] op, input logic fl, input int n);
        repeat (n) begin
            @(negedge clk);
            ex_valid = v; alu_op = op; flush = fl; rs_val = $urandom; rt_val = $urandom;
            #1;
            check("nostart_ctrl", {62'd0, stall, done}, 64'd0);
            check("nostart_hilo", {hi, lo}, {exp_hi, exp_lo});
        end
        $display("[TB] no-start v=%0b op=%04b flush=%0b for %0d cycles", v, op, fl, n);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        tests_run = 0; tests_failed = 0;
        exp_hi = '0; exp_lo = '0;
        rst = 1'b1; ex_valid = 1'b1; alu_op = ALU_MULTU; rs_val = 32'd7; rt_val = 32'd9; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {hi, lo, 30'd0, stall, done}, 96'd0);
        rst = 1'b0; ex_valid = 1'b0;
        idle_cycle();

        do_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        check("max_lo", {32'd0, lo}, 64'h0000_0001);
        idle_cycle();

        do_multu(32'h0001_2345, 32'h0001_0000, 1'b0);
        idle_cycle();
        do_multu(32'h0001_2345, 32'h0001_0000, 1'b1);
        check("latched_hi", {32'd0, hi}, 64'h1);
        check("latched_lo", {32'd0, lo}, 64'h2345_0000);
        idle_cycle();

        do_flush(32'h1234_5678, 32'h9ABC_DEF0, 5);

        do_multu(32'd3, 32'd5, 1'b0);
        check("b2b_first_lo", {32'd0, lo}, 64'd15);
        do_multu(32'd7, 32'd9, 1'b0);
        check("b2b_second", {hi, lo}, 64'd63);
        idle_cycle();

        no_start(1'b1, ALU_ADD, 1'b0, 4);
        no_start(1'b0, ALU_MULTU, 1'b0, 4);
        no_start(1'b1, ALU_MULTU, 1'b1, 4);

        // Reset in the middle of a multiply.
        @(negedge clk);
        ex_valid = 1'b1; alu_op = ALU_MULTU; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_hi = '0; exp_lo = '0;
        check("midbusy_reset", {hi, lo, 30'd0, stall, done}, 96'd0);
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0;
        #1;
        check("post_reset_idle", {62'd0, stall, done}, 64'd0);
        do_multu(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        idle_cycle();

        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: do_multu(a, b, 1'b1);
                1: do_multu(($urandom_range(0, 1) == 0) ? 32'd0 : a, ($urandom_range(0, 1) == 0) ? b : 32'd0, 1'b0);
                2: begin
                    op = 4'($urandom_range(0, 15));
                    if (op == ALU_MULTU) no_start(1'b0, op, 1'b0, 3);
                    else                 no_start(1'b1, op, 1'b0, 3);
                end
                default: do_flush(a, b, $urandom_range(1, 31));
            endcase
            idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
